// File: rtl/vga_pixel_pipe_320x240.sv
// vga_pixel_pipe_320x240: two-stage p_tick pipeline from a half-resolution frame buffer to VGA with colour modes
module vga_pixel_pipe_320x240 #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              display_switch,
    input  logic [1:0]        mode,
    input  logic [3:0]        thresh,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [11:0]       pix_data,
    output logic [11:0]       rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_done
);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] addr_next;
    logic              in_img;
    logic              video_s1;
    logic              hsync_s1;
    logic              vsync_s1;
    logic              last_s1;
    logic              cap;
    logic [11:0]       data_q;
    logic [1:0]        mode_s;
    logic [3:0]        thresh_s;
    logic [5:0]        sum;
    logic [3:0]        gray;
    logic [11:0]       proc;

    // Address is (y/2)*320 + x/2 by shift-add; colour processing of the captured pixel
    always_comb begin
        row       = ADDR_W'(y[9:1]);
        addr_next = (row << 8) + (row << 6) + ADDR_W'(x[9:1]);
        in_img    = video_on && (x < 10'(2 * IMG_W)) && (y < 10'(2 * IMG_H));
        sum       = {2'b00, data_q[11:8]} + {1'b0, data_q[7:4], 1'b0} + {2'b00, data_q[3:0]};
        gray      = sum[5:2];
        proc      = mode_s == 2'd0 ? data_q :
                    mode_s == 2'd1 ? {3{gray}} :
                    mode_s == 2'd2 ? ~data_q :
                    (gray >= thresh_s ? 12'hFFF : 12'h000);
    end

    // Stage 1: address, sync/flag copies, and frame-start latching of mode/thresh
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            pix_addr <= '0;
            video_s1 <= 1'b0;
            hsync_s1 <= 1'b0;
            vsync_s1 <= 1'b0;
            last_s1  <= 1'b0;
            mode_s   <= 2'd0;
            thresh_s <= 4'd0;
        end else if (p_tick) begin
            if (in_img)
                pix_addr <= addr_next;
            video_s1 <= video_on;
            hsync_s1 <= hsync_in;
            vsync_s1 <= vsync_in;
            last_s1  <= (x == 10'(2 * IMG_W - 1)) && (y == 10'(2 * IMG_H - 1));
            if (x == 10'd0 && y == 10'd0) begin
                mode_s   <= mode;
                thresh_s <= thresh;
            end
        end
    end

    // Frame-buffer data arrives the cycle after the address update; grab it then
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            cap    <= 1'b0;
            data_q <= 12'h000;
        end else begin
            cap <= p_tick;
            if (cap)
                data_q <= pix_data;
        end
    end

    // Stage 2: processed colour (blanked outside video or when display is off) and syncs
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            rgb   <= 12'h000;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (p_tick) begin
            rgb   <= (video_s1 && display_switch) ? proc : 12'h000;
            hsync <= hsync_s1;
            vsync <= vsync_s1;
        end
    end

    // One-clock pulse alongside the output of the last visible pixel
    always_ff @(posedge clk_100MHz) begin
        if (!reset)
            frame_done <= 1'b0;
        else
            frame_done <= p_tick && last_s1;
    end
endmodule

// File: tb/tb_vga_pixel_pipe_320x240.sv
// tb_vga_pixel_pipe_320x240: random and directed pixel ticks checked against a per-pixel reference model
module tb_vga_pixel_pipe_320x240;
    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        display_switch = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  thresh = 4'd0;
    logic [16:0] pix_addr;
    logic [11:0] pix_data;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        frame_done;

    logic [11:0] fb [76800];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_addr = 0;
    int          m_mode = 0;
    int          m_thr = 0;
    bit          p_vo = 0;
    bit          p_hs = 0;
    bit          p_vs = 0;
    bit          p_last = 0;
    int          p_mode = 0;
    int          p_thr = 0;
    logic [11:0] p_pix = '0;

    vga_pixel_pipe_320x240 dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .x(x), .y(y),
        .display_switch(display_switch), .mode(mode), .thresh(thresh),
        .pix_addr(pix_addr), .pix_data(pix_data), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .frame_done(frame_done)
    );

    // 100 MHz system clock
    always #5 clk_100MHz = ~clk_100MHz;

    assign pix_data = (pix_addr < 17'd76800) ? fb[pix_addr] : 12'h000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_rgb(input int m, input int th, input logic [11:0] p);
        int gr;
        gr = (int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0])) / 4;
        if (m == 0) return p;
        if (m == 1) return 12'(gr * 'h111);
        if (m == 2) return 12'hFFF - p;
        return (gr >= th) ? 12'hFFF : 12'h000;
    endfunction

    task automatic tick(input int xi, input int yi, input bit hs, input bit vs);
        bit vo;
        vo = (xi < 640) && (yi < 480);
        x = 10'(xi);
        y = 10'(yi);
        video_on = vo;
        hsync_in = hs;
        vsync_in = vs;
        p_tick = 1'b1;
        @(posedge clk_100MHz);
        #1;
        p_tick = 1'b0;
        chk("rgb", rgb, (p_vo && display_switch) ? ref_rgb(p_mode, p_thr, p_pix) : 12'h000);
        chk("hsync", hsync, p_hs);
        chk("vsync", vsync, p_vs);
        chk("frame_done", frame_done, p_last);
        if (xi == 0 && yi == 0) begin
            m_mode = mode;
            m_thr = thresh;
        end
        if (vo) m_addr = (yi / 2) * 320 + xi / 2;
        chk("pix_addr", pix_addr, m_addr);
        p_vo = vo;
        p_hs = hs;
        p_vs = vs;
        p_last = (xi == 639) && (yi == 479);
        p_mode = m_mode;
        p_thr = m_thr;
        p_pix = fb[m_addr];
        @(posedge clk_100MHz);
        #1;
        chk("frame_done_clr", frame_done, 0);
        repeat (3) @(negedge clk_100MHz);
    endtask

    task automatic do_reset(input int cyc);
        reset = 1'b0;
        p_tick = 1'b1;
        @(posedge clk_100MHz);
        #1;
        p_tick = 1'b0;
        chk("rst_rgb", rgb, 0);
        chk("rst_addr", pix_addr, 0);
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_fd", frame_done, 0);
        repeat (cyc - 1) @(posedge clk_100MHz);
        #1;
        reset = 1'b1;
        m_addr = 0; m_mode = 0; m_thr = 0;
        p_vo = 0; p_hs = 0; p_vs = 0; p_last = 0; p_mode = 0; p_thr = 0; p_pix = '0;
        repeat (3) @(posedge clk_100MHz);
        #1;
        chk("idle_rgb", rgb, 0);
        chk("idle_addr", pix_addr, 0);
        chk("idle_hsync", hsync, 0);
        chk("idle_vsync", vsync, 0);
        chk("idle_fd", frame_done, 0);
        @(negedge clk_100MHz);
    endtask

    // Bounded run time
    initial begin
        #2ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    // Directed scenarios, then randomized ticks
    initial begin
        foreach (fb[i]) fb[i] = 12'($urandom);
        fb[322] = 12'hA5C;
        fb[1605] = 12'hF80;
        @(negedge clk_100MHz);
        do_reset(4);
        mode = 2'd0;
        tick(0, 0, 0, 0);
        tick(5, 3, 0, 0);
        chk("addr_322", pix_addr, 322);
        tick(6, 3, 0, 0);
        chk("rgb_a5c", rgb, 12'hA5C);
        mode = 2'd1;
        tick(0, 0, 0, 0);
        tick(10, 10, 0, 0);
        tick(12, 10, 0, 0);
        chk("gray_777", rgb, 12'h777);
        mode = 2'd3;
        thresh = 4'd8;
        tick(0, 0, 0, 0);
        tick(10, 10, 0, 0);
        tick(11, 10, 0, 0);
        chk("thr8", rgb, 12'h000);
        thresh = 4'd7;
        tick(0, 0, 0, 0);
        tick(10, 10, 0, 0);
        tick(11, 10, 0, 0);
        chk("thr7", rgb, 12'hFFF);
        mode = 2'd0;
        tick(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) mode = 2'd2;
            tick(96 + 2 * i, 50, 0, 0);
        end
        tick(0, 0, 0, 0);
        tick(2, 0, 0, 0);
        chk("inv_at_start", rgb, 12'hFFF ^ fb[0]);
        for (int xi = 600; xi < 800; xi++) begin
            display_switch = !(xi >= 700 && xi < 720);
            tick(xi, 10, (xi >= 656 && xi <= 751), 0);
        end
        display_switch = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 9) == 0) thresh = 4'($urandom);
            display_switch = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 15) == 0)
                tick(0, 0, 1'($urandom), 1'($urandom));
            else
                tick($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 199) == 0) do_reset(2);
        end
        display_switch = 1'b1;
        tick(638, 479, 0, 0);
        tick(639, 479, 0, 0);
        chk("addr_last", pix_addr, 76799);
        tick(0, 480, 0, 1);
        tick(1, 480, 0, 1);
        mode = 2'd2;
        tick(0, 0, 0, 0);
        tick(10, 200, 0, 0);
        tick(11, 200, 0, 0);
        do_reset(1);
        tick(20, 200, 0, 0);
        tick(21, 200, 0, 0);
        chk("post_reset_mode", rgb, fb[32010]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
